// File: rtl/decode_iter_ctrl.sv
// Iteration controller: requests one write-FSM update pass per iteration, checks the
// syndrome after each pass and terminates on pass, on the iteration limit or on watchdog timeout.
module decode_iter_ctrl #(
    parameter int unsigned MAX_ITER       = 10,
    parameter int unsigned ITER_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_WIDTH       = 8
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  frame_start,
    input  logic [1:0]            wr_busy,
    input  logic                  syndrome_valid,
    input  logic                  syndrome_pass,
    output logic                  iter_rqst,
    output logic                  iter_termination,
    output logic [ITER_WIDTH-1:0] iter_cnt,
    output logic                  frame_ready,
    output logic                  decode_done,
    output logic                  decode_success,
    output logic                  timeout_err
);

    localparam logic [1:0]            BusyUpdate = 2'b01;
    localparam logic [1:0]            BusyFinish = 2'b10;
    localparam logic [ITER_WIDTH-1:0] MaxIter    = ITER_WIDTH'(MAX_ITER);
    localparam logic [TO_WIDTH-1:0]   WdLast     = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StCheck, StTerm} state_e;

    state_e                r_state,   w_state_d;
    logic [ITER_WIDTH-1:0] r_iter_cnt, w_iter_cnt_d;
    logic [TO_WIDTH-1:0]   r_wdog,    w_wdog_d;
    logic                  r_armed,   w_armed_d;
    logic                  r_success, w_success_d;
    logic                  r_timeout, w_timeout_d;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_iter_cnt <= '0;
            r_wdog     <= '0;
            r_armed    <= 1'b0;
            r_success  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_iter_cnt <= w_iter_cnt_d;
            r_wdog     <= w_wdog_d;
            r_armed    <= w_armed_d;
            r_success  <= w_success_d;
            r_timeout  <= w_timeout_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_iter_cnt_d = r_iter_cnt;
        w_wdog_d     = r_wdog;
        w_armed_d    = r_armed;
        w_success_d  = r_success;
        w_timeout_d  = r_timeout;
        case (r_state)
            StIdle: begin
                if (frame_start) begin
                    w_state_d    = StReq;
                    w_iter_cnt_d = '0;
                    w_wdog_d     = '0;
                    w_armed_d    = 1'b0;
                    w_success_d  = 1'b0;
                    w_timeout_d  = 1'b0;
                end
            end
            StReq: begin
                // Watchdog wins over a completion seen on the same edge
                if (r_wdog == WdLast) begin
                    w_state_d   = StTerm;
                    w_timeout_d = 1'b1;
                    w_success_d = 1'b0;
                end else if (wr_busy == BusyFinish && r_armed) begin
                    w_state_d    = StCheck;
                    w_iter_cnt_d = r_iter_cnt + ITER_WIDTH'(1);
                    w_armed_d    = 1'b0;
                end else begin
                    w_wdog_d = r_wdog + TO_WIDTH'(1);
                    // A FINISH before any UPDATE belongs to the previous pass
                    if (wr_busy == BusyUpdate) begin
                        w_armed_d = 1'b1;
                    end
                end
            end
            StCheck: begin
                if (syndrome_valid) begin
                    if (syndrome_pass) begin
                        w_state_d   = StTerm;
                        w_success_d = 1'b1;
                    end else if (r_iter_cnt == MaxIter) begin
                        w_state_d   = StTerm;
                        w_success_d = 1'b0;
                    end else begin
                        w_state_d = StReq;
                        w_wdog_d  = '0;
                        w_armed_d = 1'b0;
                    end
                end
            end
            StTerm: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign iter_rqst        = (r_state == StReq);
    assign iter_termination = (r_state == StTerm);
    assign decode_done      = (r_state == StTerm);
    assign frame_ready      = (r_state == StIdle);
    assign iter_cnt         = r_iter_cnt;
    assign decode_success   = r_success;
    assign timeout_err      = r_timeout;

endmodule
